// File: rtl/serial_divider_unit_pkg.sv
// Shared definitions for the serial restoring divider: FSM encoding and default width.
package serial_divider_unit_pkg;

    // Operand / quotient / remainder width used when the top is not overridden.
    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/serial_divider_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep or restore, and shift the quotient bit in.
module serial_divider_unit_div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;

    // Single WIDTH+1-bit subtractor; its MSB is the borrow / sign of the trial.
    always_comb begin
        r_shift = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
        trial   = r_shift - {1'b0, d_i};
        if (!trial[WIDTH]) begin
            r_o = trial;
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            r_o = r_shift;
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/serial_divider_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Holds the FSM, iteration counter, working registers and result registers.
module serial_divider_unit
    import serial_divider_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    serial_divider_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .r_i (r_q),
        .q_i (qs_q),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    // Next-state: accept in IDLE/DONE, iterate in RUN; results change only on entry to DONE.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        qs_d    = qs_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            StRun: begin
                r_d     = step_r;
                qs_d    = step_q;
                count_d = count_q + 1'b1;
                if (count_q == LastCount) begin
                    state_d = StDone;
                    quo_d   = step_q;
                    rem_d   = step_r[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                if (start) begin
                    d_d     = Y;
                    qs_d    = X;
                    r_d     = '0;
                    count_d = '0;
                    if (Y == '0) begin
                        // Divide by zero skips iteration entirely.
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = X;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            r_q     <= '0;
            qs_q    <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            qs_q    <= qs_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider_unit.sv
// Scoreboard bench for serial_divider_unit (WIDTH=16): stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_serial_divider_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    serial_divider_unit #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .X           (X),
        .Y           (Y),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: cycle counter advances at each negedge; done pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Caller is positioned just after a posedge; start is held for exactly one edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_done);
        exp_t e;
        X = x;
        Y = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_accept", 32'(busy), (y != 0) ? 32'd1 : 32'd0);
        if (expect_done) begin
            if (y == 0) begin
                e.q = '1; e.r = x; e.dbz = 1'b1; e.cyc = cyc + 1;
            end else begin
                e.q = x / y; e.r = x % y; e.dbz = 1'b0; e.cyc = cyc + W + 1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int busy_cnt;
        logic [W-1:0] rx, ry;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic divide with busy length.
        issue(16'd100, 16'd7, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd16);
        drain();

        // 2: extreme operands.
        issue(16'hFFFF, 16'd1, 1'b1);
        drain();
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        // 3: divide by zero.
        issue(16'd5, 16'd0, 1'b1);
        drain();
        chk("dbz_held", 32'(div_by_zero), 32'd1);

        // 4: starts during busy ignored, then back-to-back start in the DONE cycle.
        issue(16'd3, 16'd10, 1'b1);
        repeat (2) @(posedge clk);
        #1 begin start = 1'b1; X = 16'd9; Y = 16'd3; end
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("done_before_b2b", 32'(done), 32'd1);
        issue(16'd9, 16'd3, 1'b1);
        drain();

        // 5: reset mid-operation aborts with no done pulse.
        issue(16'd1000, 16'd9, 1'b0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        repeat (25) @(posedge clk);
        #1;

        // Start and reset together: reset wins, nothing starts.
        reset = 1'b1; start = 1'b1; X = 16'd7; Y = 16'd2;
        @(posedge clk);
        #1 begin reset = 1'b0; start = 1'b0; end
        chk("reset_wins_busy", 32'(busy), 32'd0);
        chk("reset_wins_done", 32'(done), 32'd0);
        repeat (20) @(posedge clk);
        #1;

        issue(16'd1000, 16'd9, 1'b1);
        drain();

        // 6: randomized operands against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            rx = W'($urandom);
            ry = (i % 2 == 0) ? W'($urandom_range(1, 255)) : W'($urandom_range(1, 65535));
            issue(rx, ry, 1'b1);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
